// File: rtl/usr_sequencer_if.sv
// Command handshake bundle between a host FSM and usr_sequencer.
// The host drives a command and its fields; the sequencer answers with cmd_ready.
interface usr_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [AMT_W-1:0] cmd_amt;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;

  modport master (
    output cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_amt, cmd_data, cmd_fill,
    output cmd_ready
  );

endinterface

// File: rtl/usr_sequencer.sv
// usr_sequencer: accepts one load/clear/shift/rotate command at a time and drives
// an external universal shift register for exactly the required number of cycles,
// then pulses done with result mirroring the register contents.
// Optional macro USR_SEQ_BITOUT_EN adds bit_out/bit_out_valid, which expose the
// bit leaving the register during every shift cycle.
module usr_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  usr_sequencer_if.slave   cmd,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       usr_sel,
  output logic             usr_serial_right_in,
  output logic             usr_serial_left_in,
  output logic [WIDTH-1:0] usr_parallel_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef USR_SEQ_BITOUT_EN
  ,
  output logic             bit_out,
  output logic             bit_out_valid
`endif
);

  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_q, fill_d;

  logic             is_left;
  logic             is_rot;
  logic             is_shift_op;

  assign is_left = (op_q == OP_SHL) || (op_q == OP_ROL);
  assign is_rot  = (op_q == OP_ROL) || (op_q == OP_ROR);
  assign is_shift_op = (cmd.cmd_op == OP_SHL) || (cmd.cmd_op == OP_SHR) ||
                       (cmd.cmd_op == OP_ROL) || (cmd.cmd_op == OP_ROR);

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign result        = usr_q;

  // State and latched command fields; reset aborts any command in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state: latch a command only in IDLE, then count shift cycles down to DONE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          cnt_d  = cmd.cmd_amt;
          data_d = (cmd.cmd_op == OP_CLEAR) ? '0 : cmd.cmd_data;
          fill_d = cmd.cmd_fill;
          if (cmd.cmd_op == OP_LOAD || cmd.cmd_op == OP_CLEAR) begin
            state_d = S_LOAD;
          end else if (is_shift_op && cmd.cmd_amt != '0) begin
            state_d = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        state_d = S_DONE;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // USR drive decoded from state; rotate feeds back the outgoing bit of usr_q.
  always_comb begin
    usr_sel             = 2'b00;
    usr_serial_right_in = 1'b0;
    usr_serial_left_in  = 1'b0;
    usr_parallel_in     = '0;
    case (state_q)
      S_LOAD: begin
        usr_sel         = 2'b11;
        usr_parallel_in = data_q;
      end
      S_SHIFT: begin
        if (is_left) begin
          usr_sel            = 2'b01;
          usr_serial_left_in = is_rot ? usr_q[WIDTH-1] : fill_q;
        end else begin
          usr_sel             = 2'b10;
          usr_serial_right_in = is_rot ? usr_q[0] : fill_q;
        end
      end
      default: begin
        usr_sel = 2'b00;
      end
    endcase
  end

`ifdef USR_SEQ_BITOUT_EN
  // Bit leaving the register on each shift cycle.
  always_comb begin
    bit_out       = 1'b0;
    bit_out_valid = 1'b0;
    if (state_q == S_SHIFT) begin
      bit_out_valid = 1'b1;
      bit_out       = is_left ? usr_q[WIDTH-1] : usr_q[0];
    end
  end
`endif

endmodule

// File: tb/tb_usr_sequencer.sv
// Testbench for usr_sequencer: behavioural USR model, directed command sequence,
// scoreboard of expected result/latency per command.
module tb_usr_sequencer;

  localparam int W = 4;
  localparam int A = 3;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_SHR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_CLEAR = 3'b110;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           sel_cnt;
    logic [1:0]   sel;
  } exp_t;

  logic         clk;
  logic         reset;
  logic [W-1:0] usr_q;
  logic [1:0]   usr_sel;
  logic         usr_serial_right_in;
  logic         usr_serial_left_in;
  logic [W-1:0] usr_parallel_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef USR_SEQ_BITOUT_EN
  logic         bit_out;
  logic         bit_out_valid;
`endif

  int           errors = 0;
  int           checks = 0;
  exp_t         sb[$];
  logic [W-1:0] model_val = '0;
  logic [W-1:0] usr_reg = '0;

  usr_sequencer_if #(.WIDTH(W), .AMT_W(A)) cmd_if ();

  usr_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd                 (cmd_if),
    .usr_q               (usr_q),
    .usr_sel             (usr_sel),
    .usr_serial_right_in (usr_serial_right_in),
    .usr_serial_left_in  (usr_serial_left_in),
    .usr_parallel_in     (usr_parallel_in),
    .busy                (busy),
    .done                (done),
    .result              (result)
`ifdef USR_SEQ_BITOUT_EN
    ,
    .bit_out             (bit_out),
    .bit_out_valid       (bit_out_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External universal shift register; not touched by the sequencer's reset.
  always @(posedge clk) begin
    case (usr_sel)
      2'b01:   usr_reg <= {usr_reg[W-2:0], usr_serial_left_in};
      2'b10:   usr_reg <= {usr_serial_right_in, usr_reg[W-1:1]};
      2'b11:   usr_reg <= usr_parallel_in;
      default: usr_reg <= usr_reg;
    endcase
  end
  assign usr_q = usr_reg;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_apply(input logic [2:0] op, input int amt,
                                               input logic [W-1:0] data, input logic fill,
                                               input logic [W-1:0] cur);
    logic [W-1:0] v;
    v = cur;
    case (op)
      OP_LOAD:  v = data;
      OP_CLEAR: v = '0;
      OP_SHL:   for (int i = 0; i < amt; i++) v = {v[W-2:0], fill};
      OP_SHR:   for (int i = 0; i < amt; i++) v = {fill, v[W-1:1]};
      OP_ROL:   for (int i = 0; i < amt; i++) v = {v[W-2:0], v[W-1]};
      OP_ROR:   for (int i = 0; i < amt; i++) v = {v[0], v[W-1:1]};
      default:  v = cur;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input string tag, input logic [2:0] op, input int amt,
                               input logic [W-1:0] data, input logic fill, input bit noise);
    exp_t e;
    exp_t got;
    int   w;
    int   cyc;
    int   sel_cnt;
    int   bad_sel;
    int   rdy_bad;
    bit   shift_op;
    shift_op = (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
    w = 0;
    while (!cmd_if.cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkOutput({tag, "_ready"}, 32'(cmd_if.cmd_ready), 32'd1);

    e.res = model_apply(op, amt, data, fill, model_val);
    if (op == OP_LOAD || op == OP_CLEAR) begin
      e.lat = 2; e.sel_cnt = 1; e.sel = 2'b11;
    end else if (shift_op) begin
      e.lat = (amt == 0) ? 1 : amt + 1;
      e.sel_cnt = amt;
      e.sel = (op == OP_SHL || op == OP_ROL) ? 2'b01 : 2'b10;
    end else begin
      e.lat = 1; e.sel_cnt = 0; e.sel = 2'b00;
    end
    sb.push_back(e);
    model_val = e.res;

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_amt   = A'(amt);
    cmd_if.cmd_data  = data;
    cmd_if.cmd_fill  = fill;
    @(posedge clk);
    @(negedge clk);

    sel_cnt = 0; bad_sel = 0; rdy_bad = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (usr_sel == e.sel && e.sel != 2'b00) sel_cnt++;
      else if (usr_sel != 2'b00) bad_sel++;
      if (cmd_if.cmd_ready) rdy_bad++;
`ifdef USR_SEQ_BITOUT_EN
      if (shift_op && cyc <= amt) begin
        checkOutput({tag, "_bov"}, 32'(bit_out_valid), 32'd1);
        checkOutput({tag, "_bo"}, 32'(bit_out),
                    32'((e.sel == 2'b01) ? usr_reg[W-1] : usr_reg[0]));
      end else begin
        checkOutput({tag, "_bov0"}, 32'(bit_out_valid), 32'd0);
      end
`endif
      if (done) break;
      cmd_if.cmd_valid = noise;
      cmd_if.cmd_op    = OP_CLEAR;
      cmd_if.cmd_amt   = ~A'(amt);
      cmd_if.cmd_data  = ~data;
      cmd_if.cmd_fill  = ~fill;
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;

    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(got.lat));
      checkOutput({tag, "_result"}, 32'(result), 32'(got.res));
      checkOutput({tag, "_sel_cycles"}, 32'(sel_cnt), 32'(got.sel_cnt));
    end
    checkOutput({tag, "_bad_sel"}, 32'(bad_sel), 32'd0);
    checkOutput({tag, "_ready_busy"}, 32'(rdy_bad), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_ready_after"}, 32'(cmd_if.cmd_ready), 32'd1);
  endtask

  // Directed command sequence following the intended usage of the sequencer.
  initial begin
    int done_seen;
    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_amt   = '0;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_fill  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    checkOutput("rst_sel", 32'(usr_sel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_serial", 32'({usr_serial_right_in, usr_serial_left_in}), 32'd0);
    checkOutput("rst_pin", 32'(usr_parallel_in), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus("load_1010", OP_LOAD, 0, 4'b1010, 1'b0, 1'b0);
    applyStimulus("shr2_f1",   OP_SHR,  2, 4'b0000, 1'b1, 1'b0);
    applyStimulus("rol1",      OP_ROL,  1, 4'b0000, 1'b0, 1'b0);
    applyStimulus("shl3_busy", OP_SHL,  3, 4'b0000, 1'b0, 1'b1);
    applyStimulus("shr0",      OP_SHR,  0, 4'b0000, 1'b1, 1'b0);
    applyStimulus("clear",     OP_CLEAR,0, 4'b1111, 1'b0, 1'b0);
    applyStimulus("load_0110", OP_LOAD, 0, 4'b0110, 1'b0, 1'b0);
    applyStimulus("ror5",      OP_ROR,  5, 4'b0000, 1'b0, 1'b1);
    applyStimulus("shr7_f1",   OP_SHR,  7, 4'b0000, 1'b1, 1'b0);
    applyStimulus("nop",       OP_NOP,  3, 4'b0000, 1'b0, 1'b0);

    // Abort a long shift with reset during its third shift cycle.
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_SHL;
    cmd_if.cmd_amt   = 3'd7;
    cmd_if.cmd_data  = '0;
    cmd_if.cmd_fill  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_shifting", 32'(usr_sel), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("abort_sel", 32'(usr_sel), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_ready", 32'(cmd_if.cmd_ready), 32'd1);
    checkOutput("abort_serial", 32'({usr_serial_right_in, usr_serial_left_in}), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);

    applyStimulus("load_0101", OP_LOAD, 0, 4'b0101, 1'b0, 1'b0);
    applyStimulus("ror1",      OP_ROR,  1, 4'b0000, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usr_sequencer.md
Name: usr_sequencer

Overview:
Command-driven controller that sequences an external universal shift register (USR) over its sel / serial_right_in / serial_left_in / parallel_in interface.
- Accepts one command at a time over a valid/ready handshake: load, clear, shift left/right by N, rotate left/right by N.
- Drives the USR for the exact number of cycles required, then pulses done.
- Sits between a host/control FSM and the USR datapath; the USR is not instantiated inside.

Parameters:
WIDTH, 4, USR data width in bits
AMT_W, 3, width of shift-amount field (max amount 2^AMT_W-1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 CLEAR, 111 NOP
cmd_amt  input  AMT_W  shift/rotate amount
cmd_data  input  WIDTH  parallel data for LOAD
cmd_fill  input  1  serial fill bit for SHL/SHR
usr_q  input  WIDTH  USR parallel_data_out
usr_sel  output  2  USR mode: 00 hold, 01 shift left, 10 shift right, 11 parallel load
usr_serial_right_in  output  1  USR serial input for right shift
usr_serial_left_in  output  1  USR serial input for left shift
usr_parallel_in  output  WIDTH  USR parallel load data
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle completion pulse
result  output  WIDTH  equals usr_q; valid while done=1

Behaviour:
- USR convention:
  - Shift right: q <= {serial_right_in, q[WIDTH-1:1]}.
  - Shift left: q <= {q[WIDTH-2:0], serial_left_in}.
  - Load: q <= parallel_in.
- Reset (reset=0, async):
  - state=IDLE; cmd_ready=1; usr_sel=00; serial ins=0; usr_parallel_in=0; busy=0; done=0; counter=0; latched command fields=0.
- FSM: IDLE, LOAD, SHIFT, DONE. Moore outputs, all decoded from registered state/latches.
- IDLE:
  - cmd_ready=1, usr_sel=00.
  - Accept on clk edge when cmd_valid & cmd_ready; latch op, amt, data, fill.
  - LOAD -> LOAD with parallel_in=cmd_data. CLEAR -> LOAD with parallel_in=0.
  - SHL/SHR/ROL/ROR with amt != 0 -> SHIFT, counter=amt.
  - Any shift/rotate with amt == 0 -> DONE directly (no USR activity).
  - NOP -> DONE.
- LOAD:
  - One cycle; usr_sel=11; usr_parallel_in=latched data. Next state DONE.
- SHIFT:
  - usr_sel=01 for SHL/ROL, 10 for SHR/ROR.
  - Fill: SHL uses usr_serial_left_in=fill; SHR uses usr_serial_right_in=fill.
  - Rotate: ROL uses usr_serial_left_in=usr_q[WIDTH-1]; ROR uses usr_serial_right_in=usr_q[0] (combinational from usr_q each cycle).
  - The unused serial input is held 0.
  - Counter decrements each cycle; go to DONE when counter==1 at the edge, giving exactly amt shift cycles.
  - amt > WIDTH is legal: shifting continues for the full amt cycles.
- DONE:
  - One cycle; usr_sel=00; done=1; result=usr_q (already updated). cmd_ready=0. Next state IDLE.
- Latency:
  - Accept edge to done: LOAD/CLEAR 2 cycles; shift amt N: N+1 cycles; amt 0 or NOP: 1 cycle.
  - Back-to-back commands: next accept no earlier than the cycle after DONE.
- cmd_valid while busy: ignored, not latched (cmd_ready=0).
- cmd_* inputs changing after accept: no effect.
- Reset asserted mid-operation: immediate return to reset values. USR contents are not restored. done is not issued for the aborted command.

Optional Feature:
Macro USR_SEQ_BITOUT_EN.
- Defined:
  - Adds outputs bit_out (1) and bit_out_valid (1).
  - During each SHIFT cycle, bit_out_valid=1.
  - bit_out = usr_q[0] for SHR/ROR, usr_q[WIDTH-1] for SHL/ROL (the bit leaving the register that cycle).
  - Both outputs are 0 otherwise and in reset.
- Not defined: ports absent; no logic.

Test Plan:
- Reset, then LOAD data=1010 -> usr_sel=11 for 1 cycle; done pulses 2 cycles after accept; result=1010; cmd_ready returns 1 next cycle.
- From 1010, SHR amt=2 fill=1 -> usr_sel=10 for exactly 2 cycles; result=1110; done single pulse.
- From 1110, ROL amt=1 -> result=1101. With BITOUT_EN: bit_out=1, bit_out_valid 1 cycle.
- From 1101, SHL amt=3 fill=0 -> result=1000. A second cmd_valid during the shift is not accepted; cmd_ready stays 0 until after DONE.
- SHR amt=0 -> done 1 cycle after accept; usr_sel stays 00; result unchanged (1000). CLEAR -> result=0000.
- Start SHL amt=7, assert reset low in 3rd shift cycle -> asynchronously usr_sel=00, busy=0, cmd_ready=1; no done pulse. New LOAD after release works normally.
